// File: rtl/fft_top_prod_requant.sv
// Output-side controller for the 22x15 twiddle multiplier: drives mul_ce, tracks beat validity,
// rounds/saturates the product and buffers it in a FWFT FIFO. Optional FFT_TOP_REQUANT_OVF_CNT_EN adds ovf_count.
module fft_top_prod_requant #(
  parameter int PROD_W  = 37,
  parameter int SHIFT   = 20,
  parameter int OUT_W   = 16,
  parameter int MUL_LAT = 2,
  parameter int DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              mul_ce,
  input  logic [PROD_W-1:0] mul_p,
  output logic [OUT_W-1:0]  m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              ovf_sticky
`ifdef FFT_TOP_REQUANT_OVF_CNT_EN
  ,
  output logic [15:0]       ovf_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int QW = PROD_W - SHIFT + 1;
  localparam logic [SHIFT-1:0] HALF = SHIFT'(1) << (SHIFT - 1);

  logic [AW:0]          wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OUT_W-1:0]     mem_q [DEPTH];
  logic [MUL_LAT-1:0]   vld_q, vld_d;
  logic                 ovf_q, ovf_d;
  logic                 full, empty, pop, push;
  logic [QW-2:0]        q_trunc;
  logic [SHIFT-1:0]     frac;
  logic                 round_up;
  logic signed [QW-1:0] q_rnd;
  logic                 clip;
  logic [OUT_W-1:0]     q_sat;

  // Round half to even in QW bits, then clip to the signed OUT_W range.
  always_comb begin
    q_trunc  = mul_p[PROD_W-1:SHIFT];
    frac     = mul_p[SHIFT-1:0];
    round_up = (frac > HALF) || ((frac == HALF) && q_trunc[0]);
    q_rnd    = {q_trunc[QW-2], q_trunc} + QW'(round_up);
    clip     = !((&q_rnd[QW-1:OUT_W-1]) || !(|q_rnd[QW-1:OUT_W-1]));
    if (clip) begin
      q_sat = q_rnd[QW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      q_sat = q_rnd[OUT_W-1:0];
    end
  end

  // Handshakes: a beat transfers on any rising edge where valid & ready are both high;
  // valid never depends on ready, ready (s_ready/mul_ce) may depend combinationally on m_ready.
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign m_valid = !empty;
  assign m_data  = m_valid ? mem_q[rptr_q[AW-1:0]] : '0;
  assign pop     = m_valid && m_ready;
  assign mul_ce  = rst_n && (!full || pop);
  assign s_ready = mul_ce;
  assign push    = mul_ce && vld_q[MUL_LAT-1];

  always_comb begin
    vld_d  = vld_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    if (mul_ce) begin
      vld_d = (vld_q << 1) | MUL_LAT'(s_valid);
    end
    if (push) begin
      wptr_d = wptr_q + (AW+1)'(1);
      ovf_d  = ovf_q || clip;
    end
    if (pop) begin
      rptr_d = rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
    end
  end

  // Storage needs no reset: m_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= q_sat;
    end
  end

  assign ovf_sticky = ovf_q;

`ifdef FFT_TOP_REQUANT_OVF_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (push && clip && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ovf_count = cnt_q;
`endif

endmodule
